// File: rtl/alu_arbiter_if.sv
// Handshake bundle between two ALU requesters, the arbiter and the shared ALU.
// Ports A/B: request (valid/ready/operands/ctrl), response (valid/ready/result/zero/err); alu_*: shared ALU.
interface alu_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             a_valid;
    logic             a_ready;
    logic [WIDTH-1:0] a_src_a;
    logic [WIDTH-1:0] a_src_b;
    logic [2:0]       a_ctrl;
    logic             a_rsp_valid;
    logic             a_rsp_ready;
    logic [WIDTH-1:0] a_result;
    logic             a_zero;
    logic             a_err;

    logic             b_valid;
    logic             b_ready;
    logic [WIDTH-1:0] b_src_a;
    logic [WIDTH-1:0] b_src_b;
    logic [2:0]       b_ctrl;
    logic             b_rsp_valid;
    logic             b_rsp_ready;
    logic [WIDTH-1:0] b_result;
    logic             b_zero;
    logic             b_err;

    logic [WIDTH-1:0] alu_src_a;
    logic [WIDTH-1:0] alu_src_b;
    logic [2:0]       alu_ctrl;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero;

    modport slave (
        input  a_valid, a_src_a, a_src_b, a_ctrl, a_rsp_ready,
        input  b_valid, b_src_a, b_src_b, b_ctrl, b_rsp_ready,
        input  alu_result, alu_zero,
        output a_ready, a_rsp_valid, a_result, a_zero, a_err,
        output b_ready, b_rsp_valid, b_result, b_zero, b_err,
        output alu_src_a, alu_src_b, alu_ctrl
    );

    modport master (
        output a_valid, a_src_a, a_src_b, a_ctrl, a_rsp_ready,
        output b_valid, b_src_a, b_src_b, b_ctrl, b_rsp_ready,
        output alu_result, alu_zero,
        input  a_ready, a_rsp_valid, a_result, a_zero, a_err,
        input  b_ready, b_rsp_valid, b_result, b_zero, b_err,
        input  alu_src_a, alu_src_b, alu_ctrl
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between port A (execute) and port B (debug).
// Ports: clk, rst (sync, active high), bus (alu_arbiter_if.slave: both requesters + shared ALU).
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    alu_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state;
    logic             last_b;
    logic             owner_b;
    logic             ill_q;
    logic             grant_a;
    logic             grant_b;
    logic [2:0]       sel_ctrl;
    logic             sel_ill;
    logic             rsp_take;

    logic [WIDTH-1:0] src_a_q;
    logic [WIDTH-1:0] src_b_q;
    logic [2:0]       ctrl_q;
    logic             a_rsp_valid_q;
    logic             b_rsp_valid_q;
    logic [WIDTH-1:0] a_result_q;
    logic [WIDTH-1:0] b_result_q;
    logic             a_zero_q;
    logic             b_zero_q;
    logic             a_err_q;
    logic             b_err_q;

    function automatic logic illegal(input logic [2:0] c);
        return (c == 3'b100) || (c == 3'b110) || (c == 3'b111);
    endfunction

    // On a tie the port that was not granted last wins.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (state == IDLE) begin
            grant_a = bus.a_valid && (!bus.b_valid || last_b);
            grant_b = bus.b_valid && (!bus.a_valid || !last_b);
        end
        sel_ctrl = grant_b ? bus.b_ctrl : bus.a_ctrl;
        sel_ill  = illegal(sel_ctrl);
        rsp_take = owner_b ? bus.b_rsp_ready : bus.a_rsp_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            last_b        <= 1'b1;
            owner_b       <= 1'b0;
            ill_q         <= 1'b0;
            src_a_q       <= '0;
            src_b_q       <= '0;
            ctrl_q        <= 3'b000;
            a_rsp_valid_q <= 1'b0;
            b_rsp_valid_q <= 1'b0;
            a_result_q    <= '0;
            b_result_q    <= '0;
            a_zero_q      <= 1'b0;
            b_zero_q      <= 1'b0;
            a_err_q       <= 1'b0;
            b_err_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_a || grant_b) begin
                        src_a_q <= grant_b ? bus.b_src_a : bus.a_src_a;
                        src_b_q <= grant_b ? bus.b_src_b : bus.a_src_b;
                        // Illegal codes run as a harmless add; the result is discarded.
                        ctrl_q  <= sel_ill ? 3'b000 : sel_ctrl;
                        owner_b <= grant_b;
                        last_b  <= grant_b;
                        ill_q   <= sel_ill;
                        if (grant_b) b_err_q <= sel_ill;
                        else         a_err_q <= sel_ill;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    if (owner_b) begin
                        b_result_q    <= ill_q ? '0 : bus.alu_result;
                        b_zero_q      <= ill_q ? 1'b1 : bus.alu_zero;
                        b_rsp_valid_q <= 1'b1;
                    end else begin
                        a_result_q    <= ill_q ? '0 : bus.alu_result;
                        a_zero_q      <= ill_q ? 1'b1 : bus.alu_zero;
                        a_rsp_valid_q <= 1'b1;
                    end
                    state <= RESP;
                end
                RESP: begin
                    if (rsp_take) begin
                        a_rsp_valid_q <= 1'b0;
                        b_rsp_valid_q <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.a_ready     = grant_a;
    assign bus.b_ready     = grant_b;
    assign bus.alu_src_a   = src_a_q;
    assign bus.alu_src_b   = src_b_q;
    assign bus.alu_ctrl    = ctrl_q;
    assign bus.a_rsp_valid = a_rsp_valid_q;
    assign bus.b_rsp_valid = b_rsp_valid_q;
    assign bus.a_result    = a_result_q;
    assign bus.b_result    = b_result_q;
    assign bus.a_zero      = a_zero_q;
    assign bus.b_zero      = b_zero_q;
    assign bus.a_err       = a_err_q;
    assign bus.b_err       = b_err_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: reference ALU, scoreboard of expected responses.
// Drives both requester ports through the interface and checks handshakes and timing.
module tb_alu_arbiter;
    logic clk = 1'b0;
    logic rst;

    alu_arbiter_if #(.WIDTH(32)) bus ();

    alu_arbiter #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_alu(input logic [2:0] c,
                                            input logic [31:0] x,
                                            input logic [31:0] y);
        case (c)
            3'b000:  return x + y;
            3'b001:  return x - y;
            3'b010:  return x & y;
            3'b011:  return x | y;
            3'b101:  return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // Shared ALU model sitting behind the arbiter.
    always_comb begin
        bus.alu_result = ref_alu(bus.alu_ctrl, bus.alu_src_a, bus.alu_src_b);
        bus.alu_zero   = (bus.alu_result == 32'd0);
    end

    typedef struct {
        logic        port;
        logic [31:0] res;
        logic        zero;
        logic        err;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    logic acc_a;
    logic acc_b;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t make_exp(input logic p, input logic [2:0] c,
                                      input logic [31:0] x,
                                      input logic [31:0] y);
        exp_t e;
        logic ill;
        ill    = (c == 3'b100) || (c == 3'b110) || (c == 3'b111);
        e.port = p;
        e.err  = ill;
        e.res  = ill ? 32'd0 : ref_alu(c, x, y);
        e.zero = ill ? 1'b1 : (e.res == 32'd0);
        return e;
    endfunction

    task automatic pop_chk(input logic p, input logic [31:0] r,
                           input logic z, input logic e);
        exp_t x;
        if (q.size() == 0) begin
            chk("sb_unexpected_rsp", 64'(p), 64'(2));
        end else begin
            x = q.pop_front();
            chk("sb_port", 64'(p), 64'(x.port));
            chk("sb_result", 64'(r), 64'(x.res));
            chk("sb_zero", 64'(z), 64'(x.zero));
            chk("sb_err", 64'(e), 64'(x.err));
        end
    endtask

    // Sample 1 time unit after inputs change, then advance to next negedge.
    task automatic step();
        #1;
        acc_a = bus.a_valid && bus.a_ready;
        acc_b = bus.b_valid && bus.b_ready;
        if (acc_a) q.push_back(make_exp(1'b0, bus.a_ctrl, bus.a_src_a, bus.a_src_b));
        if (acc_b) q.push_back(make_exp(1'b1, bus.b_ctrl, bus.b_src_a, bus.b_src_b));
        if (bus.a_rsp_valid && bus.a_rsp_ready)
            pop_chk(1'b0, bus.a_result, bus.a_zero, bus.a_err);
        if (bus.b_rsp_valid && bus.b_rsp_ready)
            pop_chk(1'b1, bus.b_result, bus.b_zero, bus.b_err);
        @(negedge clk);
        cyc++;
        if (acc_a) bus.a_valid = 1'b0;
        if (acc_b) bus.b_valid = 1'b0;
    endtask

    task automatic req_a(input logic [31:0] x, input logic [31:0] y,
                         input logic [2:0] c);
        bus.a_valid = 1'b1;
        bus.a_src_a = x;
        bus.a_src_b = y;
        bus.a_ctrl  = c;
    endtask

    task automatic req_b(input logic [31:0] x, input logic [31:0] y,
                         input logic [2:0] c);
        bus.b_valid = 1'b1;
        bus.b_src_a = x;
        bus.b_src_b = y;
        bus.b_ctrl  = c;
    endtask

    task automatic drain();
        logic done;
        done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (q.size() == 0 && !bus.a_valid && !bus.b_valid) begin
                done = 1'b1;
                break;
            end
            step();
        end
        chk("drain_done", 64'(done), 64'(1));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
        q.delete();
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int last;
        rst = 1'b1;
        bus.a_valid = 1'b0; bus.a_src_a = '0; bus.a_src_b = '0; bus.a_ctrl = '0;
        bus.b_valid = 1'b0; bus.b_src_a = '0; bus.b_src_b = '0; bus.b_ctrl = '0;
        bus.a_rsp_ready = 1'b1;
        bus.b_rsp_ready = 1'b1;
        @(negedge clk);
        do_reset();

        // Reset state
        chk("rst_ready", {bus.a_ready, bus.b_ready}, 0);
        chk("rst_rsp_valid", {bus.a_rsp_valid, bus.b_rsp_valid}, 0);
        chk("rst_err", {bus.a_err, bus.b_err}, 0);
        chk("rst_alu_src", {bus.alu_src_a, bus.alu_src_b}, 0);
        chk("rst_alu_ctrl", 64'(bus.alu_ctrl), 0);
        chk("rst_results", {bus.a_result, bus.b_result}, 0);
        chk("rst_zero", {bus.a_zero, bus.b_zero}, 0);

        // Single A request: 5 - 3
        req_a(32'd5, 32'd3, 3'b001);
        step();
        chk("t1_accept", {acc_a, acc_b}, 2'b10);
        chk("t1_alu_ctrl", 64'(bus.alu_ctrl), 64'(3'b001));
        chk("t1_alu_src", {bus.alu_src_a, bus.alu_src_b}, {32'd5, 32'd3});
        chk("t1_no_rsp_exec", 64'(bus.a_rsp_valid), 0);
        step();
        chk("t1_rsp_valid", 64'(bus.a_rsp_valid), 1);
        chk("t1_result", 64'(bus.a_result), 2);
        chk("t1_zero", 64'(bus.a_zero), 0);
        chk("t1_b_rsp", 64'(bus.b_rsp_valid), 0);
        step();
        chk("t1_rsp_clear", {bus.a_rsp_valid, bus.b_rsp_valid}, 0);

        // Ties: A first after reset, then B, then A again
        do_reset();
        req_a(32'd7, 32'd9, 3'b000);
        req_b(32'hF0, 32'h0F, 3'b010);
        step();
        chk("t2_tie1", {acc_a, acc_b}, 2'b10);
        step();
        step();
        req_a(32'd1, 32'd2, 3'b000);
        step();
        chk("t2_tie2", {acc_a, acc_b}, 2'b01);
        step();
        chk("t2_b_zero", {bus.b_rsp_valid, bus.b_zero, bus.a_rsp_valid}, 3'b110);
        step();
        req_b(32'd3, 32'd4, 3'b011);
        step();
        chk("t2_tie3", {acc_a, acc_b}, 2'b10);
        drain();

        // Back-pressure on B while A waits
        req_b(32'hFFFF_FFFF, 32'd1, 3'b101);
        bus.b_rsp_ready = 1'b0;
        step();
        chk("t3_accept_b", {acc_a, acc_b}, 2'b01);
        req_a(32'd10, 32'd20, 3'b000);
        step();
        chk("t3_exec_no_a", 64'(acc_a), 0);
        for (int i = 0; i < 5; i++) begin
            chk("t3_stall_valid", 64'(bus.b_rsp_valid), 1);
            chk("t3_stall_result", 64'(bus.b_result), 1);
            chk("t3_stall_a_ready", 64'(bus.a_ready), 0);
            chk("t3_stall_alu", 64'(bus.alu_ctrl), 64'(3'b101));
            step();
        end
        bus.b_rsp_ready = 1'b1;
        step();
        step();
        chk("t3_a_after", {acc_a, acc_b}, 2'b10);
        drain();

        // Illegal ctrl on A
        req_a(32'd3, 32'd4, 3'b110);
        step();
        chk("t4_accept", {acc_a, acc_b}, 2'b10);
        chk("t4_alu_ctrl", 64'(bus.alu_ctrl), 0);
        step();
        chk("t4_rsp", {bus.a_rsp_valid, bus.a_err, bus.a_zero}, 3'b111);
        chk("t4_result", 64'(bus.a_result), 0);
        step();
        req_a(32'd2, 32'd2, 3'b000);
        step();
        chk("t4_err_clear", 64'(bus.a_err), 0);
        drain();

        // Reset during EXEC
        req_a(32'd9, 32'd9, 3'b001);
        step();
        chk("t5_accept", {acc_a, acc_b}, 2'b10);
        do_reset();
        chk("t5_rsp", {bus.a_rsp_valid, bus.b_rsp_valid}, 0);
        chk("t5_alu", {bus.alu_src_a, bus.alu_src_b}, 0);
        chk("t5_ctrl", 64'(bus.alu_ctrl), 0);
        chk("t5_res", {bus.a_result, bus.a_zero, bus.a_err}, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t5_no_rsp", 64'(bus.a_rsp_valid), 0);
        end
        req_a(32'd1, 32'd1, 3'b000);
        req_b(32'd2, 32'd2, 3'b000);
        step();
        chk("t5_tie", {acc_a, acc_b}, 2'b10);
        drain();

        // Continuous A traffic: one accept every 3 cycles
        last = 0;
        for (int k = 0; k < 6; k++) begin
            req_a(32'(k * 3), 32'(k + 1), (k % 2 == 1) ? 3'b001 : 3'b000);
            for (int i = 0; i < 10; i++) begin
                step();
                if (acc_a) break;
            end
            chk("t6_accept", 64'(acc_a), 1);
            if (k > 0) chk("t6_gap", 64'(cyc - last), 3);
            last = cyc;
        end
        drain();

        chk("sb_empty", 64'(q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single ALU of the RISC-V core between two requesters: port A (core execute path) and port B (debug / self-test engine). Requests arrive on valid/ready handshakes, are granted round-robin, and the winning operands and ALUControl code are registered onto the shared ALU inputs. The result and zero flag are captured and returned on a per-port response handshake. One transaction is in flight at a time.

## Interface
- WIDTH, 32, operand and result width
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- a_valid / b_valid  input  1  request valid, port A / B
- a_ready / b_ready  output  1  request accepted this cycle
- a_src_a, a_src_b / b_src_a, b_src_b  input  WIDTH  operands
- a_ctrl / b_ctrl  input  3  ALUControl code: 000 add, 001 sub, 010 and, 011 or, 101 slt
- a_rsp_valid / b_rsp_valid  output  1  response valid
- a_rsp_ready / b_rsp_ready  input  1  requester takes response
- a_result / b_result  output  WIDTH  captured ALU result
- a_zero / b_zero  output  1  captured zero flag
- a_err / b_err  output  1  request carried an illegal ctrl code
- alu_src_a, alu_src_b  output  WIDTH  registered operands to shared ALU
- alu_ctrl  output  3  registered ALUControl to shared ALU
- alu_result  input  WIDTH  combinational ALU result
- alu_zero  input  1  combinational ALU zero flag

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state IDLE.
- IDLE: if any valid, select winner; winner's ready = 1 combinationally; on the edge, register operands/ctrl into alu_*, record owner, go to EXEC. Loser's ready = 0.
- Arbitration: only one valid -> that port wins. Both valid -> port not granted last wins; last-grant pointer resets to B, so A wins the first tie. Pointer updates only on accept.
- EXEC (exactly one cycle): alu_* stable; on the edge capture alu_result and alu_zero into owner's result/zero registers, go to RESP.
- RESP: owner's rsp_valid = 1, result/zero/err held stable until owner's rsp_ready = 1; on that edge clear rsp_valid, go to IDLE. Non-owner's rsp_valid stays 0.
- Illegal ctrl (100, 110, 111): request still accepted and sequenced; alu_ctrl driven 000, captured result forced 0, zero forced 1, err = 1. err cleared on next accept for that port.
- Requester rule: valid and payload held stable until ready; ready may depend on valid. Arbiter never drops an accepted request except on rst.
- ready is 0 in EXEC and RESP for both ports; no accept in the same cycle as a response handshake.
- result/zero/err registers hold their last values after response; only rsp_valid qualifies them.

## Timing
- Reset (rst high on an edge): state IDLE, pointer = B, all ready/rsp_valid/err = 0, alu_src_a/alu_src_b/alu_ctrl = 0, results = 0, zero = 0. Applies mid-transaction: in-flight request discarded, no response issued.
- Accept at edge N -> alu_* valid in cycle N+1 -> rsp_valid high from cycle N+2.
- Minimum occupancy 3 cycles (accept, exec, response with rsp_ready already high); back-to-back throughput one transaction per 3 cycles.
- rsp_ready low stalls in RESP indefinitely; alu_* stay at last values.
- ALU path is combinational alu_* -> alu_result within one cycle; no other combinational path from alu_result to outputs.

## Test plan
- Single A request: src_a=5, src_b=3, ctrl=001, rsp_ready=1 -> a_ready high cycle 0, alu_ctrl=001 cycle 1, a_rsp_valid cycle 2, a_result=2, a_zero=0, b_rsp_valid never high.
- Simultaneous A (ctrl=000, 7+9) and B (ctrl=010, 0xF0 & 0x0F) held valid -> A served first (result 16), then B (result 0, b_zero=1), then a third tie goes to A.
- Back-pressure: B request ctrl=101, src_a=0xFFFFFFFF, src_b=1, b_rsp_ready low 5 cycles -> b_rsp_valid held, b_result=1 stable, a_ready stays 0 though a_valid=1 throughout.
- Illegal ctrl 110 on A -> accepted, alu_ctrl=000, a_err=1, a_result=0, a_zero=1; next legal A request clears a_err.
- rst asserted during EXEC of an A request -> next cycle all outputs at reset values, no a_rsp_valid; subsequent tie granted to A.
- Continuous A-only traffic with rsp_ready=1 -> exactly one accept every 3 cycles, results in order.
